lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
- Load/store sequencer between the multi-cycle core's MEM stage and the byte-organised, word-ported data memory.
- Accepts one load/store request at a time and aligns the address to the word port.
- Sub-word stores are done as read-modify-write; sub-word loads are extracted and sign/zero-extended.
- Faults (illegal size, misalignment, out-of-range) are reported without touching memory.

Parameters:
ADDR_BITS, 12, byte-address width of the data memory; the legal range is 0 .. 2^ADDR_BITS-1.

Ports:
clk  input  1  clock; all state changes on the rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  core presents a request
req_ready  output  1  controller idle; request accepted on an edge where req_valid && req_ready
req_write  input  1  1 = store, 0 = load
req_funct3  input  3  RISC-V funct3 (size/sign)
req_addr  input  32  byte address
req_wdata  input  32  store data; the low byte/half is used for SB/SH
resp_valid  output  1  one-cycle pulse: request complete
resp_rdata  output  32  load result; 0 for stores and faults
resp_fault  output  1  request faulted; no memory access performed
resp_cause  output  2  0 none, 1 misaligned, 2 out of range, 3 illegal funct3
mem_read  output  1  to data memory
mem_write  output  1  to data memory
mem_addr  output  32  word-aligned address {addr_q[31:2],2'b00}
mem_wdata  output  32  full word to write
mem_rdata  input  32  registered memory read data; valid the cycle after mem_read is sampled

Behaviour:
- Reset values: state IDLE; all registers 0; req_ready=1; resp_valid=0; resp_fault=0; resp_cause=0; resp_rdata=0; mem_read=0; mem_write=0; mem_addr=0; mem_wdata=0.
- mem_read, mem_write and req_ready are decoded from the state register, so reset deasserts them immediately.
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else is illegal.
- Fault checks at acceptance, in priority order illegal > misaligned > range:
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Out of range: addr >= 2^ADDR_BITS.
- At acceptance, latch write, funct3, addr and wdata; drop req_ready.
- States:
  - IDLE: on accept, go to RESP if faulted (latch cause); else READ for any load or SB/SH; else WRITE for SW.
  - READ: mem_read=1, mem_addr aligned. Next: CAPTURE.
  - CAPTURE: mem_rdata valid.
    - Load: select the byte by addr_q[1:0] or the half by addr_q[1]; sign-extend (LB/LH) or zero-extend (LBU/LHU); LW passes through; register into resp_rdata; go to RESP.
    - SB/SH: merge the low byte/half of wdata_q into mem_rdata at the addressed lane; register into merge_q; go to WRITE.
  - WRITE: mem_write=1 for exactly one cycle; mem_wdata = wdata_q (SW) or merge_q (SB/SH). Next: RESP.
  - RESP: resp_valid=1 for one cycle; resp_rdata/resp_fault/resp_cause stable. Next: IDLE.
- resp_* hold their values until the next acceptance, which clears them.
- Latency, counted in cycles after the accept edge, to the resp_valid cycle:
  - Fault: 1.
  - SW: 2.
  - Load: 3.
  - SB/SH: 4.
- No response backpressure. req_valid while busy is ignored, and the core must hold it until accepted.
- Back-to-back: RESP goes to IDLE; the next request can be accepted in the IDLE cycle.
- A faulted request never asserts mem_read or mem_write.
- Reset mid-operation returns to IDLE:
  - A store aborted before WRITE leaves memory unchanged.
  - No resp_valid is issued for the aborted request.

Test Plan:
- Preload bytes 0x100..0x103 = BB,AA,99,88. LB 0x103 -> 0xFFFFFF88; LBU 0x103 -> 0x00000088; LH 0x102 -> 0xFFFF8899; LHU 0x100 -> 0x0000AABB; LW 0x100 -> 0x8899AABB. Each resp_valid 3 cycles after accept; mem_addr=0x100 throughout.
- SB 0x101 with wdata 0x12345677 -> one READ, one mem_write with mem_wdata=0x889977BB, resp at cycle 4; a following LW 0x100 returns 0x889977BB. SH 0x102 with 0xFFFFCAFE -> word 0xCAFE77BB.
- SW 0x104 with 0xDEADBEEF -> mem_write only (no mem_read), resp at cycle 2, resp_rdata=0; LW 0x104 returns 0xDEADBEEF.
- Faults, each with resp at cycle 1, resp_rdata=0 and no mem_read/mem_write:
  - LW 0x102 -> cause 1.
  - SH 0x101 -> cause 1.
  - LW 0x1000 -> cause 2.
  - funct3=011 -> cause 3.
  - funct3=011 at 0x1001 -> cause 3 (priority).
- Assert reset while in CAPTURE of SB 0x100 with 0xFF -> mem_write never asserts, memory word unchanged, no resp_valid; req_ready=1 after reset release.
- Hold req_valid high across LW, SW, LB issued back-to-back -> each accepted only while req_ready=1; responses arrive in order, one resp_valid pulse each.

Source files
------------

// File: rtl/lsu_mem_ctrl_if.sv
// Request/response and data-memory signals between the MEM stage, the load/store
// sequencer and the word-ported data memory.
interface lsu_mem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [1:0]  resp_cause;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // master: core plus memory side; slave: the sequencer
    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault, resp_cause,
        input  mem_read, mem_write, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_fault, resp_cause,
        output mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer: word-aligned memory access, read-modify-write for
// sub-word stores, sign/zero extension for sub-word loads, fault reporting.
module lsu_mem_ctrl #(
    parameter int ADDR_BITS = 12
) (
    input  logic          clk,
    input  logic          reset,
    lsu_mem_ctrl_if.slave bus
);

    typedef enum logic [2:0] {IDLE, READ, CAPTURE, WRITE, RESP} state_t;

    state_t      state;
    logic        write_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] merge_q;
    logic [31:0] rdata_q;
    logic        fault_q;
    logic [1:0]  cause_q;

    logic        accept;
    logic [1:0]  req_cause;

    // Priority: illegal funct3 > misaligned > out of range.
    function automatic logic [1:0] fault_cause(input logic wr, input logic [2:0] f3,
                                               input logic [31:0] addr);
        logic illegal;
        logic misaligned;
        logic out_of_range;
        illegal      = wr ? (f3 > 3'b010) : (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
        misaligned   = (f3[1:0] == 2'b01 && addr[0]) || (f3[1:0] == 2'b10 && addr[1:0] != 2'b00);
        out_of_range = {1'b0, addr} >= (33'd1 << ADDR_BITS);
        if (illegal)           return 2'd3;
        else if (misaligned)   return 2'd1;
        else if (out_of_range) return 2'd2;
        else                   return 2'd0;
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] word);
        logic [31:0]        lane;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] r;
        lane = word >> {off, 3'b000};
        b    = lane[7:0];
        h    = lane[15:0];
        case (f3)
            3'b000:  r = b;
            3'b001:  r = h;
            3'b100:  r = {24'd0, lane[7:0]};
            3'b101:  r = {16'd0, lane[15:0]};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_merge(input logic half, input logic [1:0] off,
                                                input logic [31:0] word, input logic [31:0] wd);
        logic [4:0]  sh;
        logic [31:0] mask;
        logic [31:0] lane;
        sh   = {off, 3'b000};
        mask = (half ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
        lane = wd << sh;
        return (word & ~mask) | (lane & mask);
    endfunction

    assign accept    = bus.req_valid && (state == IDLE);
    assign req_cause = fault_cause(bus.req_write, bus.req_funct3, bus.req_addr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            write_q  <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            merge_q  <= 32'd0;
            rdata_q  <= 32'd0;
            fault_q  <= 1'b0;
            cause_q  <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        write_q  <= bus.req_write;
                        funct3_q <= bus.req_funct3;
                        addr_q   <= bus.req_addr;
                        wdata_q  <= bus.req_wdata;
                        rdata_q  <= 32'd0;
                        fault_q  <= (req_cause != 2'd0);
                        cause_q  <= req_cause;
                        if (req_cause != 2'd0)
                            state <= RESP;
                        else if (!bus.req_write || bus.req_funct3[1:0] != 2'b10)
                            state <= READ;
                        else
                            state <= WRITE;
                    end
                end
                READ: state <= CAPTURE;
                CAPTURE: begin
                    // mem_rdata holds the word addressed in READ
                    if (write_q) begin
                        merge_q <= store_merge(funct3_q[0], addr_q[1:0], bus.mem_rdata, wdata_q);
                        state   <= WRITE;
                    end else begin
                        rdata_q <= load_extract(funct3_q, addr_q[1:0], bus.mem_rdata);
                        state   <= RESP;
                    end
                end
                WRITE:   state <= RESP;
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.mem_read   = (state == READ);
    assign bus.mem_write  = (state == WRITE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_fault = fault_q;
    assign bus.resp_cause = cause_q;
    assign bus.mem_addr   = {addr_q[31:2], 2'b00};
    assign bus.mem_wdata  = (funct3_q[1:0] == 2'b10) ? wdata_q : merge_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: table of single requests plus reset-abort
// and back-to-back sequences against a byte-lane word memory model.
module tb_lsu_mem_ctrl;

    logic clk = 1'b0;
    logic reset;
    logic preload;
    int   checks = 0;
    int   failures = 0;

    lsu_mem_ctrl_if bus ();

    lsu_mem_ctrl #(.ADDR_BITS(12)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:1023];

    // Registered read: data appears the cycle after mem_read is sampled
    always @(posedge clk) begin
        if (preload) mem[64] <= 32'h8899_AABB;
        if (bus.mem_read)  bus.mem_rdata <= mem[bus.mem_addr[11:2]];
        if (bus.mem_write) mem[bus.mem_addr[11:2]] <= bus.mem_wdata;
    end

    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        fault;
        logic [1:0]  cause;
        int          lat;
        int          reads;
        int          writes;
        logic [31:0] mwdata;
    } vec_t;

    function automatic vec_t mkv(logic wr, logic [2:0] f3, logic [31:0] addr, logic [31:0] wdata,
                                 logic [31:0] rdata, logic fault, logic [1:0] cause,
                                 int lat, int reads, int writes, logic [31:0] mwdata);
        vec_t v;
        v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.fault = fault; v.cause = cause; v.lat = lat; v.reads = reads;
        v.writes = writes; v.mwdata = mwdata;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.req_write  = v.wr;
        bus.req_funct3 = v.f3;
        bus.req_addr   = v.addr;
        bus.req_wdata  = v.wdata;
    endtask

    // Starts at a negedge with the DUT idle; ends at the negedge of resp_valid.
    task automatic run_vec(input vec_t v, input int idx);
        int          lat;
        int          reads;
        int          writes;
        int          addr_bad;
        logic [31:0] wd;
        lat = 99; reads = 0; writes = 0; addr_bad = 0; wd = 32'd0;
        @(negedge clk);
        check($sformatf("v%0d.ready", idx), {31'd0, bus.req_ready}, 32'd1);
        drive(v);
        bus.req_valid = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) bus.req_valid = 1'b0;
            if (bus.mem_read) reads++;
            if (bus.mem_write) begin
                writes++;
                wd = bus.mem_wdata;
            end
            if ((bus.mem_read || bus.mem_write) && bus.mem_addr !== {v.addr[31:2], 2'b00})
                addr_bad++;
            if (bus.resp_valid) begin
                lat = c;
                break;
            end
        end
        check($sformatf("v%0d.latency", idx), lat, v.lat);
        check($sformatf("v%0d.rdata", idx), bus.resp_rdata, v.rdata);
        check($sformatf("v%0d.fault", idx), {31'd0, bus.resp_fault}, {31'd0, v.fault});
        check($sformatf("v%0d.cause", idx), {30'd0, bus.resp_cause}, {30'd0, v.cause});
        check($sformatf("v%0d.reads", idx), reads, v.reads);
        check($sformatf("v%0d.writes", idx), writes, v.writes);
        check($sformatf("v%0d.mem_addr_bad", idx), addr_bad, 0);
        if (v.writes != 0) check($sformatf("v%0d.mem_wdata", idx), wd, v.mwdata);
    endtask

    vec_t        vecs [24];
    vec_t        b2b [3];
    logic [31:0] b2b_exp [3];
    logic [31:0] got [3];
    logic [31:0] word_before;
    int          seen_w;
    int          seen_r;
    int          idx;
    int          nresp;
    int          cyc;
    int          last_cyc;
    logic        started;
    logic        acc;

    initial begin
        vecs[0]  = mkv(0, 3'b000, 32'h103, 0, 32'hFFFF_FF88, 0, 0, 3, 1, 0, 0);
        vecs[1]  = mkv(0, 3'b100, 32'h103, 0, 32'h0000_0088, 0, 0, 3, 1, 0, 0);
        vecs[2]  = mkv(0, 3'b001, 32'h102, 0, 32'hFFFF_8899, 0, 0, 3, 1, 0, 0);
        vecs[3]  = mkv(0, 3'b101, 32'h100, 0, 32'h0000_AABB, 0, 0, 3, 1, 0, 0);
        vecs[4]  = mkv(0, 3'b010, 32'h100, 0, 32'h8899_AABB, 0, 0, 3, 1, 0, 0);
        vecs[5]  = mkv(1, 3'b000, 32'h101, 32'h1234_5677, 0, 0, 0, 4, 1, 1, 32'h8899_77BB);
        vecs[6]  = mkv(0, 3'b010, 32'h100, 0, 32'h8899_77BB, 0, 0, 3, 1, 0, 0);
        vecs[7]  = mkv(1, 3'b001, 32'h102, 32'hFFFF_CAFE, 0, 0, 0, 4, 1, 1, 32'hCAFE_77BB);
        vecs[8]  = mkv(0, 3'b010, 32'h100, 0, 32'hCAFE_77BB, 0, 0, 3, 1, 0, 0);
        vecs[9]  = mkv(0, 3'b000, 32'h101, 0, 32'h0000_0077, 0, 0, 3, 1, 0, 0);
        vecs[10] = mkv(0, 3'b000, 32'h100, 0, 32'hFFFF_FFBB, 0, 0, 3, 1, 0, 0);
        vecs[11] = mkv(0, 3'b101, 32'h102, 0, 32'h0000_CAFE, 0, 0, 3, 1, 0, 0);
        vecs[12] = mkv(1, 3'b010, 32'h104, 32'hDEAD_BEEF, 0, 0, 0, 2, 0, 1, 32'hDEAD_BEEF);
        vecs[13] = mkv(0, 3'b010, 32'h104, 0, 32'hDEAD_BEEF, 0, 0, 3, 1, 0, 0);
        vecs[14] = mkv(1, 3'b010, 32'hFFC, 32'h7E12_3456, 0, 0, 0, 2, 0, 1, 32'h7E12_3456);
        vecs[15] = mkv(0, 3'b100, 32'hFFF, 0, 32'h0000_007E, 0, 0, 3, 1, 0, 0);
        vecs[16] = mkv(0, 3'b000, 32'hFFC, 0, 32'h0000_0056, 0, 0, 3, 1, 0, 0);
        vecs[17] = mkv(0, 3'b010, 32'h102, 0, 0, 1, 1, 1, 0, 0, 0);
        vecs[18] = mkv(1, 3'b001, 32'h101, 32'h1111_2222, 0, 1, 1, 1, 0, 0, 0);
        vecs[19] = mkv(0, 3'b010, 32'h1000, 0, 0, 1, 2, 1, 0, 0, 0);
        vecs[20] = mkv(0, 3'b011, 32'h100, 0, 0, 1, 3, 1, 0, 0, 0);
        vecs[21] = mkv(0, 3'b011, 32'h1001, 0, 0, 1, 3, 1, 0, 0, 0);
        vecs[22] = mkv(1, 3'b100, 32'h100, 32'h55, 0, 1, 3, 1, 0, 0, 0);
        vecs[23] = mkv(0, 3'b001, 32'hFFE, 0, 32'h0000_7E12, 0, 0, 3, 1, 0, 0);

        b2b[0] = mkv(0, 3'b010, 32'h104, 0, 0, 0, 0, 0, 0, 0, 0);
        b2b[1] = mkv(1, 3'b010, 32'h108, 32'h0102_038C, 0, 0, 0, 0, 0, 0, 0);
        b2b[2] = mkv(0, 3'b000, 32'h108, 0, 0, 0, 0, 0, 0, 0, 0);
        b2b_exp[0] = 32'hDEAD_BEEF;
        b2b_exp[1] = 32'h0000_0000;
        b2b_exp[2] = 32'hFFFF_FF8C;

        reset = 1'b1;
        preload = 1'b1;
        bus.req_valid = 1'b0;
        drive(vecs[0]);
        repeat (3) @(negedge clk);
        check("rst.req_ready",  {31'd0, bus.req_ready}, 32'd1);
        check("rst.resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("rst.resp_fault", {31'd0, bus.resp_fault}, 32'd0);
        check("rst.resp_cause", {30'd0, bus.resp_cause}, 32'd0);
        check("rst.resp_rdata", bus.resp_rdata, 32'd0);
        check("rst.mem_read",   {31'd0, bus.mem_read}, 32'd0);
        check("rst.mem_write",  {31'd0, bus.mem_write}, 32'd0);
        check("rst.mem_addr",   bus.mem_addr, 32'd0);
        check("rst.mem_wdata",  bus.mem_wdata, 32'd0);
        reset = 1'b0;
        preload = 1'b0;

        for (int i = 0; i < 24; i++) run_vec(vecs[i], i);

        // Abort an SB in CAPTURE: memory must stay untouched, no response
        word_before = mem[64];
        @(negedge clk);
        drive(mkv(1, 3'b000, 32'h100, 32'h0000_00FF, 0, 0, 0, 0, 0, 0, 0));
        bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("abort.in_read", {31'd0, bus.mem_read}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort.ready_now", {31'd0, bus.req_ready}, 32'd1);
        check("abort.write_now", {31'd0, bus.mem_write}, 32'd0);
        seen_w = 0; seen_r = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.mem_write) seen_w++;
            if (bus.resp_valid) seen_r++;
        end
        check("abort.mem_write_seen", seen_w, 0);
        check("abort.resp_seen", seen_r, 0);
        check("abort.mem_word", mem[64], word_before);
        check("abort.ready_after", {31'd0, bus.req_ready}, 32'd1);

        // Back-to-back LW, SW, LB with req_valid held high throughout
        idx = 0; nresp = 0; cyc = 0; last_cyc = -1; started = 1'b0;
        drive(b2b[0]);
        bus.req_valid = 1'b1;
        for (int c = 0; c < 40 && nresp < 3; c++) begin
            acc = bus.req_valid && bus.req_ready;
            @(negedge clk);
            if (acc && idx == 0) started = 1'b1;
            if (started) cyc++;
            if (acc) begin
                idx++;
                if (idx < 3) drive(b2b[idx]);
                else bus.req_valid = 1'b0;
            end
            if (bus.resp_valid) begin
                got[nresp] = bus.resp_rdata;
                if (nresp == 2) last_cyc = cyc;
                nresp++;
            end
        end
        bus.req_valid = 1'b0;
        check("b2b.accepts", idx, 3);
        check("b2b.responses", nresp, 3);
        check("b2b.last_resp_cycle", last_cyc, 10);
        for (int i = 0; i < 3; i++)
            check($sformatf("b2b.rdata%0d", i), (nresp > i) ? got[i] : 32'hXXXX_XXXX, b2b_exp[i]);
        @(negedge clk);
        check("b2b.resp_pulse_end", {31'd0, bus.resp_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
